// File: rtl/mc_packetizer.sv
// mc_packetizer: buffers payloads from NUM_CH channels in per-channel FIFOs, round-robin arbitrates,
// and serialises each payload onto one link as a header beat followed by N_PKTS data beats.
module mc_packetizer #(
  parameter int NUM_CH          = 2,
  parameter int CH_BITS         = 1,
  parameter int PAYLOAD_WIDTH   = 128,
  parameter int PACKET_WIDTH    = 16,
  parameter int DEPTH           = 4,
  parameter int N_PKTS_BITS     = 4,
  parameter int THROTTLE        = 0,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 payload_req_i,
  input  logic [NUM_CH*PAYLOAD_WIDTH-1:0]   payload_i,
  output logic [NUM_CH-1:0]                 payload_grant_o,
  output logic [NUM_CH-1:0]                 push_af_o,
  output logic                              packet_req_o,
  output logic                              lock_o,
  output logic [PACKET_WIDTH-1:0]           packet_o,
  input  logic                              packet_grant_i,
  input  logic                              packet_received_i,
  output logic [3:0]                        outstanding_o
);
  localparam int N_PKTS = PAYLOAD_WIDTH / PACKET_WIDTH;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF = CW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
  localparam logic [N_PKTS_BITS-1:0] LAST = N_PKTS_BITS'(N_PKTS - 1);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [PAYLOAD_WIDTH-1:0] mem [NUM_CH][DEPTH];
  logic [PW-1:0] wr_ptr [NUM_CH];
  logic [PW-1:0] rd_ptr [NUM_CH];
  logic [CW-1:0] count [NUM_CH];
  logic [NUM_CH-1:0] push, pop;
  logic [1:0] state;
  logic [CH_BITS-1:0] sel, rr, nxt, idx;
  logic found, last_beat, start;
  logic [N_PKTS_BITS-1:0] beat;
  logic [3:0] outstanding;
  logic [PAYLOAD_WIDTH-1:0] head;
  logic [PACKET_WIDTH-1:0] header;

  assign last_beat = (state == DATA) && (beat == LAST);
  assign payload_grant_o = push;
  assign outstanding_o = outstanding;
  assign packet_req_o = state == REQ;
  assign lock_o = state != IDLE;
  assign head = mem[sel][rd_ptr[sel]];
  assign header = PACKET_WIDTH'({N_PKTS_BITS'(N_PKTS), sel, 1'b1});
  assign packet_o = state == REQ ? header :
                    state == DATA ? head[beat*PACKET_WIDTH +: PACKET_WIDTH] : '0;

  // fullness uses the pre-pop count, so a full channel refuses even while being popped
  always_comb begin
    push = '0;
    pop = '0;
    push_af_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push[c] = payload_req_i[c] && (count[c] != FULL);
      pop[c] = last_beat && (sel == CH_BITS'(c));
      push_af_o[c] = count[c] >= AF;
    end
  end

  always_comb begin
    found = 1'b0;
    nxt = rr;
    idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_BITS'((int'(rr) + i) % NUM_CH);
      if (!found && count[idx] != '0) begin
        found = 1'b1;
        nxt = idx;
      end
    end
    start = found && (THROTTLE == 0 || outstanding < MAX_OUT);
  end

  always_ff @(posedge clk)
    for (int c = 0; c < NUM_CH; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= payload_i[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] == PTR_MAX ? '0 : wr_ptr[c] + PW'(1);
        if (pop[c]) rd_ptr[c] <= rd_ptr[c] == PTR_MAX ? '0 : rd_ptr[c] + PW'(1);
        count[c] <= count[c] + CW'(push[c]) - CW'(pop[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      rr <= CH_BITS'(NUM_CH - 1);
      beat <= '0;
      outstanding <= '0;
    end else begin
      if (state == IDLE && start) begin
        sel <= nxt;
        rr <= nxt;
        state <= REQ;
      end else if (state == REQ && packet_grant_i) begin
        beat <= '0;
        state <= DATA;
      end else if (state == DATA) begin
        beat <= beat + N_PKTS_BITS'(1);
        if (last_beat) state <= IDLE;
      end
      if (last_beat && !packet_received_i && outstanding != 4'd15) outstanding <= outstanding + 4'd1;
      else if (!last_beat && packet_received_i && outstanding != 4'd0) outstanding <= outstanding - 4'd1;
    end
  end
endmodule
